// File: rtl/snn_run_controller.sv
// Run sequencer for the two-layer spiking network: drives rate-coded
// input spike trains for a window, counts output spikes, reports them.
module snn_run_controller #(
   parameter int WIN_W  = 8,
   parameter int CNT_W  = 8,
   parameter int SETTLE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   input  logic [2:0]       cfg_addr1,
   input  logic [2:0]       cfg_addr2,
   input  logic [WIN_W-1:0] cfg_window,
   input  logic [3:0]       cfg_period1,
   input  logic [3:0]       cfg_period2,
   input  logic [3:0]       cfg_period3,
   output logic [2:0]       weight_addr1,
   output logic [2:0]       weight_addr2,
   output logic             spk_1,
   output logic             spk_2,
   output logic             spk_3,
   input  logic             spk_7,
   input  logic             spk_8,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_count7,
   output logic [CNT_W-1:0] res_count8,
   output logic [2:0]       res_addr1,
   output logic [2:0]       res_addr2
);

   localparam int FL_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      FLUSH,
      REPORT
   } state_t;

   state_t           state;
   logic [WIN_W-1:0] win_q;
   logic [WIN_W-1:0] win_cnt;
   logic [FL_W-1:0]  fl_cnt;
   logic [2:0][3:0]  per_q;
   logic [2:0][3:0]  ph_q;
   logic [2:0]       hit;
   logic [2:0]       spk_q;

   assign spk_1 = spk_q[0];
   assign spk_2 = spk_q[1];
   assign spk_3 = spk_q[2];

   // An input fires when its phase reaches period-1; period 0 never fires.
   always_comb begin
      hit = '0;
      for (int i = 0; i < 3; i++) begin
         hit[i] = (per_q[i] != 4'd0) && (ph_q[i] == per_q[i] - 4'd1);
      end
   end

   // Run sequencing, rate generation, output counting and result hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         res_valid    <= 1'b0;
         win_q        <= '0;
         win_cnt      <= '0;
         fl_cnt       <= '0;
         per_q        <= '0;
         ph_q         <= '0;
         spk_q        <= '0;
         weight_addr1 <= '0;
         weight_addr2 <= '0;
         res_addr1    <= '0;
         res_addr2    <= '0;
         res_count7   <= '0;
         res_count8   <= '0;
      end else begin
         spk_q <= '0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  win_q        <= cfg_window;
                  per_q        <= {cfg_period3, cfg_period2, cfg_period1};
                  ph_q         <= '0;
                  win_cnt      <= '0;
                  fl_cnt       <= '0;
                  weight_addr1 <= cfg_addr1;
                  weight_addr2 <= cfg_addr2;
                  res_addr1    <= cfg_addr1;
                  res_addr2    <= cfg_addr2;
                  res_count7   <= '0;
                  res_count8   <= '0;
                  busy         <= 1'b1;
                  state        <= (cfg_window == '0) ? FLUSH : DRIVE;
               end
            end
            DRIVE: begin
               spk_q <= hit;
               for (int i = 0; i < 3; i++) begin
                  ph_q[i] <= hit[i] ? 4'd0 : ph_q[i] + 4'd1;
               end
               if (spk_7 && res_count7 != '1)
                  res_count7 <= res_count7 + CNT_W'(1);
               if (spk_8 && res_count8 != '1)
                  res_count8 <= res_count8 + CNT_W'(1);
               if (win_cnt == win_q - WIN_W'(1))
                  state <= FLUSH;
               else
                  win_cnt <= win_cnt + WIN_W'(1);
            end
            FLUSH: begin
               if (spk_7 && res_count7 != '1)
                  res_count7 <= res_count7 + CNT_W'(1);
               if (spk_8 && res_count8 != '1)
                  res_count8 <= res_count8 + CNT_W'(1);
               if (fl_cnt == FL_W'(SETTLE - 1)) begin
                  state     <= REPORT;
                  res_valid <= 1'b1;
               end else begin
                  fl_cnt <= fl_cnt + FL_W'(1);
               end
            end
            REPORT: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snn_run_controller.sv
// Self-checking bench for snn_run_controller: run-level reference model
// compared every cycle, plus directed literal checks.
module tb_snn_run_controller;

   localparam int WIN_W  = 8;
   localparam int CNT_W  = 4;
   localparam int SETTLE = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start = 1'b0;
   logic             busy;
   logic [2:0]       cfg_addr1 = '0;
   logic [2:0]       cfg_addr2 = '0;
   logic [WIN_W-1:0] cfg_window = '0;
   logic [3:0]       cfg_period1 = '0;
   logic [3:0]       cfg_period2 = '0;
   logic [3:0]       cfg_period3 = '0;
   logic [2:0]       weight_addr1;
   logic [2:0]       weight_addr2;
   logic             spk_1, spk_2, spk_3;
   logic             spk_7 = 1'b0;
   logic             spk_8 = 1'b0;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [CNT_W-1:0] res_count7, res_count8;
   logic [2:0]       res_addr1, res_addr2;

   always #5 clk = ~clk;

   snn_run_controller #(
      .WIN_W (WIN_W),
      .CNT_W (CNT_W),
      .SETTLE(SETTLE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .busy        (busy),
      .cfg_addr1   (cfg_addr1),
      .cfg_addr2   (cfg_addr2),
      .cfg_window  (cfg_window),
      .cfg_period1 (cfg_period1),
      .cfg_period2 (cfg_period2),
      .cfg_period3 (cfg_period3),
      .weight_addr1(weight_addr1),
      .weight_addr2(weight_addr2),
      .spk_1       (spk_1),
      .spk_2       (spk_2),
      .spk_3       (spk_3),
      .spk_7       (spk_7),
      .spk_8       (spk_8),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_count7  (res_count7),
      .res_count8  (res_count8),
      .res_addr1   (res_addr1),
      .res_addr2   (res_addr2)
   );

   int n_pass = 0;
   int n_tot  = 0;
   int mode   = 0;

   // Run-level model: t = cycles elapsed since the accepting edge.
   bit m_busy = 1'b0;
   int t      = 0;
   int mW     = 0;
   int mp[3]  = '{0, 0, 0};
   int ma1    = 0;
   int ma2    = 0;
   int mc7    = 0;
   int mc8    = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic model_step();
      if (rst) begin
         m_busy = 1'b0; t = 0; mW = 0; mp = '{0, 0, 0};
         ma1 = 0; ma2 = 0; mc7 = 0; mc8 = 0;
         return;
      end
      if (m_busy) begin
         if (t < mW + SETTLE) begin
            if (spk_7 && mc7 < CMAX) mc7++;
            if (spk_8 && mc8 < CMAX) mc8++;
         end
         if (t >= mW + SETTLE && res_ready) m_busy = 1'b0;
         else t++;
      end else if (start) begin
         m_busy = 1'b1; t = 0; mW = int'(cfg_window);
         mp[0] = int'(cfg_period1);
         mp[1] = int'(cfg_period2);
         mp[2] = int'(cfg_period3);
         ma1 = int'(cfg_addr1); ma2 = int'(cfg_addr2);
         mc7 = 0; mc8 = 0;
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   task automatic compare();
      bit ev;
      int es;
      ev = m_busy && (t >= mW + SETTLE);
      es = 0;
      if (m_busy && t >= 1 && t <= mW)
         for (int i = 0; i < 3; i++)
            if (mp[i] != 0 && (t % mp[i]) == 0) es |= (1 << i);
      chk("busy", int'(busy), int'(m_busy));
      chk("res_valid", int'(res_valid), int'(ev));
      chk("spk", int'({spk_3, spk_2, spk_1}), es);
      chk("weight_addr", int'({weight_addr1, weight_addr2}), ma1 * 8 + ma2);
      if (ev) begin
         chk("res_count7", int'(res_count7), mc7);
         chk("res_count8", int'(res_count8), mc8);
         chk("res_addr", int'({res_addr1, res_addr2}), ma1 * 8 + ma2);
      end
      if (rst) begin
         chk("rst_counts", int'({res_count7, res_count8}), 0);
         chk("rst_res_addr", int'({res_addr1, res_addr2}), 0);
      end
   endtask

   initial forever begin
      @(negedge clk);
      compare();
   end

   // Stub network on spk_7/spk_8.
   initial forever begin
      @(posedge clk);
      #1;
      case (mode)
         0: begin spk_7 = 1'($urandom); spk_8 = 1'($urandom); end
         1: begin spk_7 = 1'b1; spk_8 = 1'b0; end
         2: begin spk_7 = spk_1 & spk_2; spk_8 = spk_3; end
         default: begin spk_7 = 1'b0; spk_8 = 1'b0; end
      endcase
   end

   // Called #1 after a rising edge; returns #1 after the handshake edge.
   task automatic run(input int w, input int p1, input int p2, input int p3,
                      input int a1, input int a2, input int wait_c,
                      input bit poke, input bit early,
                      output int lat, output int ns1, output int ns2,
                      output int ns3, output int c7, output int c8);
      bit done;
      done = 1'b0;
      lat = 0; ns1 = 0; ns2 = 0; ns3 = 0; c7 = 0; c8 = 0;
      cfg_window  = WIN_W'(w);
      cfg_period1 = 4'(p1);
      cfg_period2 = 4'(p2);
      cfg_period3 = 4'(p3);
      cfg_addr1   = 3'(a1);
      cfg_addr2   = 3'(a2);
      start     = 1'b1;
      res_ready = early;
      @(posedge clk);
      #1;
      start       = 1'b0;
      cfg_window  = WIN_W'($urandom);
      cfg_period1 = 4'($urandom);
      cfg_period2 = 4'($urandom);
      cfg_period3 = 4'($urandom);
      cfg_addr1   = 3'($urandom);
      cfg_addr2   = 3'($urandom);
      while (!done && lat < 600) begin
         @(negedge clk);
         lat++;
         ns1 += int'(spk_1);
         ns2 += int'(spk_2);
         ns3 += int'(spk_3);
         if (res_valid) begin
            done = 1'b1;
            c7 = int'(res_count7);
            c8 = int'(res_count8);
         end
      end
      chk("run_reaches_report", int'(done), 1);
      if (!early) begin
         for (int k = 0; k < wait_c; k++) begin
            @(posedge clk);
            #1;
            if (poke) start = 1'($urandom);
         end
         start     = 1'b0;
         res_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      start     = 1'b0;
   endtask

   initial begin
      int lat, s1, s2, s3, c7, c8;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      mode = 1;
      run(10, 3, 1, 0, 2, 5, 3, 1'b0, 1'b0, lat, s1, s2, s3, c7, c8);
      chk("A_latency", lat, 15);
      chk("A_spk1_pulses", s1, 3);
      chk("A_spk2_pulses", s2, 10);
      chk("A_spk3_pulses", s3, 0);
      chk("A_count7", c7, 14);
      chk("A_count8", c8, 0);

      run(30, 0, 0, 0, 1, 1, 0, 1'b0, 1'b0, lat, s1, s2, s3, c7, c8);
      chk("B_count7_sat", c7, 15);

      mode = 0;
      run(0, 2, 2, 2, 3, 4, 7, 1'b1, 1'b0, lat, s1, s2, s3, c7, c8);
      chk("C_latency", lat, 5);
      chk("C_spikes", s1 + s2 + s3, 0);

      cfg_window  = 8'd20;
      cfg_period1 = 4'd2;
      cfg_period2 = 4'd3;
      cfg_addr1   = 3'd5;
      cfg_addr2   = 3'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("D_busy", int'(busy), 0);
      chk("D_valid", int'(res_valid), 0);
      chk("D_spk", int'({spk_3, spk_2, spk_1}), 0);
      chk("D_waddr", int'({weight_addr1, weight_addr2}), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mode = 1;
      run(10, 1, 0, 0, 6, 1, 1, 1'b0, 1'b0, lat, s1, s2, s3, c7, c8);
      chk("D_fresh_count7", c7, 14);

      mode = 2;
      for (int r = 0; r < 2; r++) begin
         run(40, 1, 1, 1, 7, 7, 0, 1'b0, 1'b0, lat, s1, s2, s3, c7, c8);
         chk("E_waddr1", int'(weight_addr1), 7);
         chk("E_waddr2", int'(weight_addr2), 7);
         chk("E_count7_nonzero", int'(c7 > 0), 1);
         chk("E_count8_nonzero", int'(c8 > 0), 1);
      end

      mode = 0;
      for (int r = 0; r < 16; r++) begin
         run($urandom_range(0, 40), $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 5), 1'($urandom), (r % 5) == 4,
             lat, s1, s2, s3, c7, c8);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
